logcmp_issue: RTL

Issue buffer for the logic/compare execute unit. Holds up to DP dispatched logic/compare micro-ops (slt[u], xor, or, and) until their physical source registers are ready. Reads operands from the register file and issues one op per cycle as a registered `logCmp_exeparam` bundle to the single-cycle `logCmp` execute stage. Sits between dispatch and execute; it is the issuing end of the `logCmp_exeparam_vaild`/`logCmp_exeparam` interface.

---
 rtl/logcmp_issue.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/logcmp_issue.sv
// Issue buffer for the logic/compare execute unit: holds dispatched ops until sources are ready, issues one per cycle.
// Define LOGCMP_ISSUE_AGE_EN to select the oldest ready entry; otherwise the lowest-index ready entry issues.
module logcmp_issue #(
  parameter int DP    = 4,
  parameter int RNBIT = 2
) (
  input  logic                         CLK,
  input  logic                         RSTn,
  input  logic                         flush,
  input  logic                         dispat_vaild,
  output logic                         dispat_ready,
  input  logic [3:0]                   dispat_fun,
  input  logic                         dispat_isUsi,
  input  logic [5+RNBIT-1:0]           dispat_rd0,
  input  logic [5+RNBIT-1:0]           dispat_rs1,
  input  logic [5+RNBIT-1:0]           dispat_rs2,
  input  logic                         dispat_isImm,
  input  logic [63:0]                  dispat_imm,
  input  logic [(1<<(5+RNBIT))-1:0]    wbLog_qout,
  output logic [5+RNBIT-1:0]           rs1_raddr,
  output logic [5+RNBIT-1:0]           rs2_raddr,
  input  logic [63:0]                  rs1_rdata,
  input  logic [63:0]                  rs2_rdata,
  output logic                         logCmp_exeparam_vaild,
  output logic [138+RNBIT-1:0]         logCmp_exeparam
);

  localparam int RW = 5 + RNBIT;
  localparam int IW = (DP > 1) ? $clog2(DP) : 1;
  localparam int DW = 138 + RNBIT;

  logic [DP-1:0] r_valid;
  logic [3:0]    r_fun   [DP];
  logic          r_isusi [DP];
  logic [RW-1:0] r_rd0   [DP];
  logic [RW-1:0] r_rs1   [DP];
  logic [RW-1:0] r_rs2   [DP];
  logic          r_isimm [DP];
  logic [63:0]   r_imm   [DP];

  logic          r_exe_vld;
  logic [DW-1:0] r_exe;

  logic [DP-1:0] w_rdy;
  logic          w_sel_vld;
  logic [IW-1:0] w_sel_idx;
  logic [IW-1:0] w_free_idx;
  logic          w_push;
  logic [63:0]   w_op2;
  logic [DW-1:0] w_bundle;

  assign dispat_ready = ~&r_valid;
  assign w_push       = dispat_vaild & dispat_ready & ~flush;

  // Physical register 0 is always ready; the regfile returns 0 for it.
  always_comb begin
    w_rdy = '0;
    for (int i = 0; i < DP; i++) begin
      w_rdy[i] = r_valid[i]
               & ((r_rs1[i] == '0) | wbLog_qout[r_rs1[i]])
               & (r_isimm[i] | (r_rs2[i] == '0) | wbLog_qout[r_rs2[i]]);
    end
  end

  always_comb begin
    w_free_idx = '0;
    for (int i = DP-1; i >= 0; i--) begin
      if (!r_valid[i]) w_free_idx = IW'(i);
    end
  end

`ifdef LOGCMP_ISSUE_AGE_EN
  // r_older[i][j] set means entry i was pushed before entry j.
  logic [DP-1:0] r_older [DP];
  logic          w_oldest;

  always_comb begin
    w_sel_vld = 1'b0;
    w_sel_idx = '0;
    w_oldest  = 1'b0;
    for (int i = 0; i < DP; i++) begin
      w_oldest = w_rdy[i];
      for (int j = 0; j < DP; j++) begin
        if ((j != i) && w_rdy[j] && !r_older[i][j]) w_oldest = 1'b0;
      end
      if (w_oldest) begin
        w_sel_vld = 1'b1;
        w_sel_idx = IW'(i);
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int i = 0; i < DP; i++) r_older[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < DP; i++) r_older[i] <= '0;
    end else begin
      if (w_sel_vld) r_older[w_sel_idx] <= '0;
      if (w_push) begin
        for (int j = 0; j < DP; j++) begin
          r_older[w_free_idx][j] <= 1'b0;
          r_older[j][w_free_idx] <= r_valid[j] & ~(w_sel_vld & (w_sel_idx == IW'(j)));
        end
      end
    end
  end
`else
  always_comb begin
    w_sel_vld = 1'b0;
    w_sel_idx = '0;
    for (int i = DP-1; i >= 0; i--) begin
      if (w_rdy[i]) begin
        w_sel_vld = 1'b1;
        w_sel_idx = IW'(i);
      end
    end
  end
`endif

  assign rs1_raddr = w_sel_vld ? r_rs1[w_sel_idx] : '0;
  assign rs2_raddr = w_sel_vld ? r_rs2[w_sel_idx] : '0;
  assign w_op2     = r_isimm[w_sel_idx] ? r_imm[w_sel_idx] : rs2_rdata;
  assign w_bundle  = {r_fun[w_sel_idx], r_rd0[w_sel_idx], rs1_rdata, w_op2, r_isusi[w_sel_idx]};

  // A slot freed by issue is never the push target in the same cycle, since the
  // push target is chosen from slots that are currently invalid.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_valid   <= '0;
      r_exe_vld <= 1'b0;
      r_exe     <= '0;
      for (int i = 0; i < DP; i++) begin
        r_fun[i]   <= '0;
        r_isusi[i] <= 1'b0;
        r_rd0[i]   <= '0;
        r_rs1[i]   <= '0;
        r_rs2[i]   <= '0;
        r_isimm[i] <= 1'b0;
        r_imm[i]   <= '0;
      end
    end else if (flush) begin
      r_valid   <= '0;
      r_exe_vld <= 1'b0;
    end else begin
      r_exe_vld <= w_sel_vld;
      if (w_sel_vld) begin
        r_exe              <= w_bundle;
        r_valid[w_sel_idx] <= 1'b0;
      end
      if (w_push) begin
        r_valid[w_free_idx] <= 1'b1;
        r_fun[w_free_idx]   <= dispat_fun;
        r_isusi[w_free_idx] <= dispat_isUsi;
        r_rd0[w_free_idx]   <= dispat_rd0;
        r_rs1[w_free_idx]   <= dispat_rs1;
        r_rs2[w_free_idx]   <= dispat_rs2;
        r_isimm[w_free_idx] <= dispat_isImm;
        r_imm[w_free_idx]   <= dispat_imm;
      end
    end
  end

  assign logCmp_exeparam_vaild = r_exe_vld;
  assign logCmp_exeparam       = r_exe;

endmodule
